evm_multi: RTL and testbench
============================

# evm_multi

Parametrised electronic voting machine core: NUM_CAND candidate buttons, saturating per-candidate tallies, a one-vote-per-ballot state machine with invalid-press rejection, an election-close lock, and a registered tally readout port. It is the successor of the three-candidate voting block. It sits between the debounced button/ballot-officer inputs and the result display and readout logic.

## Interface
- NUM_CAND, 4: number of candidates, 2..16.
- CNT_W, 8: tally width; each tally saturates at 2^CNT_W-1.
- LED_HOLD, 3: cycles the vote LED stays lit after a cast, 1..255.
- Clk  input  1  single clock, all logic on rising edge.
- Rst  input  1  synchronous, active-high reset.
- ballot  input  1  officer enable; one vote accepted per high period.
- vote  input  NUM_CAND  candidate buttons, bit i = candidate i.
- close  input  1  end election; level or pulse.
- cnt_sel  input  $clog2(NUM_CAND)  tally index to read.
- cnt_out  output  CNT_W  registered tally of cnt_sel.
- total  output  CNT_W+$clog2(NUM_CAND)  count of accepted votes.
- invalid_cnt  output  CNT_W  count of rejected casts, saturating.
- led  output  NUM_CAND  one-hot lamp of the last accepted vote.
- err  output  1  lit during SHOW after a rejected cast.
- ready  output  1  high in IDLE.
- closed  output  1  high in CLOSED.
- winner  output  $clog2(NUM_CAND)  present only with EVM_WINNER_EN.
- tie  output  1  present only with EVM_WINNER_EN.
- result_valid  output  1  present only with EVM_WINNER_EN.

## Operation
- States: IDLE, ARMED, SHOW, CLOSED.
- IDLE -> ARMED when ballot==1 and vote==0. Pressed buttons block arming.
- ARMED with exactly one vote bit set:
  - If that tally is below max: tally+1, total+1, led=that bit, err=0, go to SHOW.
  - If that tally is saturated: no increment, invalid_cnt+1, led=0, err=1, go to SHOW.
- ARMED with two or more vote bits set: no tally change, invalid_cnt+1, led=0, err=1, go to SHOW.
- ARMED with vote==0: remain in ARMED.
- SHOW: load a hold counter with LED_HOLD on entry and decrement it each cycle. Go to IDLE when hold==0, ballot==0 and vote==0. led and err clear on entry to IDLE. A ballot held high therefore yields exactly one vote.
- close==1 in any state: go to CLOSED next cycle. close has priority over a same-cycle cast, which is not counted. led and err clear.
- CLOSED: all tallies frozen and inputs ignored. Only Rst exits CLOSED.
- Readout works in every state. cnt_out <= tally[cnt_sel]. An out-of-range cnt_sel returns 0.
- Reset: all tallies, total, invalid_cnt, cnt_out, led and err = 0. State = IDLE, so ready=1 and closed=0. Winner outputs = 0.

## Timing
- A cast is sampled on the first ARMED cycle with vote!=0. The tally, total and led update on the following edge.
- Minimum ballot-to-ballot time: 1 (arm) + 1 (cast) + LED_HOLD + 1 cycles.
- cnt_out latency: 1 cycle from cnt_sel. It reflects the updated tally 1 cycle after an increment.
- Rst mid-operation: the next edge returns to reset values regardless of state, including CLOSED.

## Configuration
- EVM_WINNER_EN defined: on entry to CLOSED, a sequential scanner steps through index 0..NUM_CAND-1, one tally per cycle.
  - winner = index of the maximum tally. On equal maxima the lowest index wins.
  - tie = 1 if two or more candidates share the maximum, including all-zero tallies.
  - result_valid rises NUM_CAND+1 cycles after closed rises and holds until Rst.
- EVM_WINNER_EN undefined: the scanner and the winner, tie and result_valid ports are absent. All other behaviour is identical.

## Structure
- Package evm_pkg holds:
  - the state enum (IDLE, ARMED, SHOW, CLOSED);
  - a function that tests whether vote has exactly one bit set;
  - a one-hot-to-index function.
- Sub-module evm_winner_scan holds the EVM_WINNER_EN scanner and takes the tally array, start and done signals.

## Test plan
- Single vote (NUM_CAND=4, LED_HOLD=3): ballot=1, vote=0010, then release both -> tally[1]=1, total=1, led=0010 for at least 3 cycles, then ready=1.
- Held ballot: ballot stays high and vote=0001 is pressed twice -> tally[0]=1 only; re-arm happens only after ballot goes 0 then 1.
- Invalid press: vote=0101 in ARMED -> all tallies unchanged, invalid_cnt=1, err=1, led=0000.
- Saturation (CNT_W=2): 4 valid votes for candidate 3 -> tally[3]=3, invalid_cnt=1, total=3.
- Close race: close=1 in the same cycle as vote=1000 in ARMED -> tally[3] unchanged and closed=1; later ballots are ignored until Rst.
- Winner (EVM_WINNER_EN): tallies {2,5,5,1}, then close -> result_valid after 5 cycles, winner=1, tie=1. Rst then clears every output to 0 with ready=1.

Source files
------------

// File: rtl/evm_pkg.sv
// rtl/evm_pkg.sv - state encoding and vote decoding helpers shared by the evm_multi slice
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        SHOW   = 2'd2,
        CLOSED = 2'd3
    } evm_state_e;

    localparam int MAX_CAND = 16;
    localparam int HOLD_W   = 8;

    function automatic logic is_onehot(input logic [MAX_CAND-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Only meaningful for a one-hot input; multi-hot inputs yield an OR of indices.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_CAND-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CAND; i++) begin
            if (v[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/evm_winner_scan.sv
// rtl/evm_winner_scan.sv - sequential max-tally scanner used when EVM_WINNER_EN is defined
module evm_winner_scan #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_CAND-1:0][CNT_W-1:0]  tally_i,
    input  logic                            start_i,
    output logic                            done_o,
    output logic [$clog2(NUM_CAND)-1:0]     winner_o,
    output logic                            tie_o
);
    localparam int SEL_W = $clog2(NUM_CAND);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tie_q, tie_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] best_q, best_d;
    logic [CNT_W-1:0] cur;

    assign cur = tally_i[idx_q];

    always_comb begin
        busy_d     = busy_q;
        done_d     = done_q;
        tie_d      = tie_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_d     = best_q;
        if (start_i && !busy_q && !done_q) begin
            busy_d = 1'b1;
            idx_d  = '0;
        end else if (busy_q) begin
            // Strict greater-than keeps the lowest index on equal maxima.
            if (idx_q == '0 || cur > best_q) begin
                best_d     = cur;
                best_idx_d = idx_q;
                tie_d      = 1'b0;
            end else if (cur == best_q) begin
                tie_d = 1'b1;
            end
            if (idx_q == SEL_W'(NUM_CAND - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tie_q      <= 1'b0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            tie_q      <= tie_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
        end
    end

    assign done_o   = done_q;
    assign winner_o = done_q ? best_idx_q : '0;
    assign tie_o    = done_q & tie_q;

endmodule

// File: rtl/evm_multi.sv
// rtl/evm_multi.sv - voting machine core with saturating tallies and readout; EVM_WINNER_EN adds winner/tie/result_valid
module evm_multi
    import evm_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int LED_HOLD = 3
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic                                ballot,
    input  logic [NUM_CAND-1:0]                 vote,
    input  logic                                close,
    input  logic [$clog2(NUM_CAND)-1:0]         cnt_sel,
    output logic [CNT_W-1:0]                    cnt_out,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]   total,
    output logic [CNT_W-1:0]                    invalid_cnt,
    output logic [NUM_CAND-1:0]                 led,
    output logic                                err,
    output logic                                ready,
    output logic                                closed
`ifdef EVM_WINNER_EN
    ,
    output logic [$clog2(NUM_CAND)-1:0]         winner,
    output logic                                tie,
    output logic                                result_valid
`endif
);
    localparam int SEL_W = $clog2(NUM_CAND);
    localparam int TOT_W = CNT_W + SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    evm_state_e                     state_q, state_d;
    logic [HOLD_W-1:0]              hold_q, hold_d;
    logic [NUM_CAND-1:0][CNT_W-1:0] tally_q, tally_d;
    logic [TOT_W-1:0]               total_q, total_d;
    logic [CNT_W-1:0]               inv_q, inv_d;
    logic [CNT_W-1:0]               cnt_out_q, cnt_out_d;
    logic [NUM_CAND-1:0]            led_q, led_d;
    logic                           err_q, err_d;
    logic [SEL_W-1:0]               cast_idx;
    logic                           cast_ok;

    assign cast_idx = SEL_W'(onehot_to_idx(MAX_CAND'(vote)));
    assign cast_ok  = is_onehot(MAX_CAND'(vote)) && (tally_q[cast_idx] != CNT_MAX);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tally_d = tally_q;
        total_d = total_q;
        inv_d   = inv_q;
        led_d   = led_q;
        err_d   = err_q;
        // close overrides any same-cycle cast so a late press is never counted
        if (close) begin
            state_d = CLOSED;
            led_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ballot && vote == '0) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (vote != '0) begin
                        state_d = SHOW;
                        hold_d  = HOLD_W'(LED_HOLD);
                        if (cast_ok) begin
                            tally_d[cast_idx] = tally_q[cast_idx] + 1'b1;
                            total_d           = total_q + 1'b1;
                            led_d             = vote;
                            err_d             = 1'b0;
                        end else begin
                            if (inv_q != CNT_MAX) begin
                                inv_d = inv_q + 1'b1;
                            end
                            led_d = '0;
                            err_d = 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end
                    // Requiring ballot low here is what limits a held ballot to one vote.
                    if (hold_q == '0 && !ballot && vote == '0) begin
                        state_d = IDLE;
                        led_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        cnt_out_d = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cnt_sel == SEL_W'(i)) begin
                cnt_out_d = tally_q[i];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            tally_q   <= '0;
            total_q   <= '0;
            inv_q     <= '0;
            cnt_out_q <= '0;
            led_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            tally_q   <= tally_d;
            total_q   <= total_d;
            inv_q     <= inv_d;
            cnt_out_q <= cnt_out_d;
            led_q     <= led_d;
            err_q     <= err_d;
        end
    end

    assign cnt_out     = cnt_out_q;
    assign total       = total_q;
    assign invalid_cnt = inv_q;
    assign led         = led_q;
    assign err         = err_q;
    assign ready       = (state_q == IDLE);
    assign closed      = (state_q == CLOSED);

`ifdef EVM_WINNER_EN
    evm_winner_scan #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W)
    ) u_scan (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .tally_i  (tally_q),
        .start_i  (state_q == CLOSED),
        .done_o   (result_valid),
        .winner_o (winner),
        .tie_o    (tie)
    );
`endif

endmodule

// File: tb/tb_evm_multi.sv
// tb/tb_evm_multi.sv - self-checking bench for evm_multi with a transaction-level voting model
`timescale 1ns/1ps
module tb_evm_multi;
    localparam int NC   = 4;
    localparam int CW   = 3;
    localparam int LH   = 3;
    localparam int SW   = 2;
    localparam int TW   = CW + SW;
    localparam int CMAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          ballot = 1'b0;
    logic          close = 1'b0;
    logic [NC-1:0] vote = '0;
    logic [SW-1:0] cnt_sel = '0;
    logic [CW-1:0] cnt_out;
    logic [CW-1:0] invalid_cnt;
    logic [TW-1:0] total;
    logic [NC-1:0] led;
    logic          err, ready, closed;
`ifdef EVM_WINNER_EN
    logic [SW-1:0] winner;
    logic          tie, result_valid;
`endif

    int m_tally[NC];
    int m_total, m_inv, m_led, m_err, m_ready, m_closed, m_cnt_out;
    int m_rv, m_winner, m_tie;
    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int last_led, last_err;

    evm_multi #(.NUM_CAND(NC), .CNT_W(CW), .LED_HOLD(LH)) dut (
        .Clk(Clk), .Rst(Rst), .ballot(ballot), .vote(vote), .close(close),
        .cnt_sel(cnt_sel), .cnt_out(cnt_out), .total(total), .invalid_cnt(invalid_cnt),
        .led(led), .err(err), .ready(ready), .closed(closed)
`ifdef EVM_WINNER_EN
        , .winner(winner), .tie(tie), .result_valid(result_valid)
`endif
    );

    always #5 Clk = ~Clk;

    // readout is the pre-edge tally of the pre-edge selection
    always @(posedge Clk) m_cnt_out <= Rst ? 0 : m_tally[cnt_sel];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_tally[i] = 0;
        m_total = 0; m_inv = 0; m_led = 0; m_err = 0;
        m_ready = 1; m_closed = 0;
        m_rv = 0; m_winner = 0; m_tie = 0;
    endtask

    task automatic model_cast(input logic [NC-1:0] v);
        int idx;
        bit ok;
        idx = 0;
        ok = 1'b0;
        if ($countones(v) == 1) begin
            for (int i = 0; i < NC; i++) if (v[i]) idx = i;
            ok = (m_tally[idx] < CMAX);
        end
        if (ok) begin
            m_tally[idx]++;
            m_total++;
            m_led = int'(v);
            m_err = 0;
        end else begin
            if (m_inv < CMAX) m_inv++;
            m_led = 0;
            m_err = 1;
        end
    endtask

    task automatic model_close();
        m_closed = 1; m_ready = 0; m_led = 0; m_err = 0;
    endtask

    task automatic model_winner();
        int mx, cnt;
        mx = 0;
        cnt = 0;
        m_winner = -1;
        for (int i = 0; i < NC; i++) if (m_tally[i] > mx) mx = m_tally[i];
        for (int i = 0; i < NC; i++) begin
            if (m_tally[i] == mx) begin
                cnt++;
                if (m_winner < 0) m_winner = i;
            end
        end
        m_tie = (cnt >= 2) ? 1 : 0;
        m_rv = 1;
    endtask

    // full ballot: arm, optional idle ARMED cycles, cast, release, wait out SHOW
    task automatic cast(input logic [NC-1:0] v, input int arm_wait);
        ballot = 1'b1; vote = '0;
        tick(); m_ready = 0;
        repeat (arm_wait) tick();
        vote = v;
        tick(); model_cast(v);
        last_led = int'(led);
        last_err = int'(err);
        ballot = 1'b0; vote = '0;
        repeat (LH) tick();
        tick(); m_ready = 1; m_led = 0; m_err = 0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick(); model_reset();
        Rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                chk("total", int'(total), m_total);
                chk("invalid_cnt", int'(invalid_cnt), m_inv);
                chk("led", int'(led), m_led);
                chk("err", int'(err), m_err);
                chk("ready", int'(ready), m_ready);
                chk("closed", int'(closed), m_closed);
                chk("cnt_out", int'(cnt_out), m_cnt_out);
`ifdef EVM_WINNER_EN
                chk("result_valid", int'(result_valid), m_rv);
                if (m_rv != 0) begin
                    chk("winner", int'(winner), m_winner);
                    chk("tie", int'(tie), m_tie);
                end
`endif
            end
        end
    end

    initial begin
        repeat (2) tick();
        model_reset();
        Rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_closed", int'(closed), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_led", int'(led), 0);

        cast(4'b0010, 0);
        chk("single_led", last_led, 2);
        cnt_sel = 2'd1;
        tick();
        chk("single_tally1", int'(cnt_out), 1);
        chk("single_total", int'(total), 1);

        // held ballot: second press while ballot stays high is ignored
        ballot = 1'b1; vote = '0;
        tick(); m_ready = 0;
        vote = 4'b0001;
        tick(); model_cast(4'b0001);
        vote = '0;
        repeat (5) tick();
        vote = 4'b0001;
        repeat (2) tick();
        vote = '0;
        tick();
        ballot = 1'b0;
        tick(); m_ready = 1; m_led = 0; m_err = 0;
        cnt_sel = 2'd0;
        tick();
        chk("held_tally0", int'(cnt_out), 1);
        chk("held_total", int'(total), 2);

        // a pressed button blocks arming
        ballot = 1'b1; vote = 4'b0100;
        repeat (2) tick();
        chk("block_arm_ready", int'(ready), 1);
        ballot = 1'b0; vote = '0;
        tick();

        cast(4'b0101, 2);
        chk("invalid_err", last_err, 1);
        chk("invalid_led", last_led, 0);
        chk("invalid_cnt1", int'(invalid_cnt), 1);

        for (int n = 0; n < CMAX + 1; n++) cast(4'b1000, 0);
        cnt_sel = 2'd3;
        tick();
        chk("sat_tally3", int'(cnt_out), 7);
        chk("sat_total", int'(total), 9);
        chk("sat_invalid", int'(invalid_cnt), 2);
        chk("sat_err", last_err, 1);

        // close pulse during SHOW, then ignored ballots in CLOSED
        ballot = 1'b1;
        tick(); m_ready = 0;
        vote = 4'b0100;
        tick(); model_cast(4'b0100);
        ballot = 1'b0; vote = '0;
        tick();
        close = 1'b1;
        tick(); model_close();
        close = 1'b0;
        chk("show_close_closed", int'(closed), 1);
        chk("show_close_led", int'(led), 0);
        ballot = 1'b1;
        tick();
        vote = 4'b0001;
        tick();
        ballot = 1'b0; vote = '0;
        tick();
        chk("closed_frozen_total", int'(total), 10);

        do_reset();
        chk("rst2_total", int'(total), 0);
        chk("rst2_ready", int'(ready), 1);
        chk("rst2_closed", int'(closed), 0);

        // tallies {2,5,5,1}, then close races a cast for candidate 3
        repeat (2) cast(4'b0001, 0);
        repeat (5) cast(4'b0010, 0);
        repeat (5) cast(4'b0100, 0);
        cast(4'b1000, 0);
        ballot = 1'b1;
        tick(); m_ready = 0;
        vote = 4'b1000; close = 1'b1;
        tick(); model_close();
        close = 1'b0; ballot = 1'b0; vote = '0;
        for (int k = 1; k <= NC + 1; k++) begin
            tick();
`ifdef EVM_WINNER_EN
            if (k == NC + 1) model_winner();
`endif
        end
`ifdef EVM_WINNER_EN
        chk("win_valid", int'(result_valid), 1);
        chk("win_index", int'(winner), 1);
        chk("win_tie", int'(tie), 1);
`endif
        cnt_sel = 2'd3;
        tick();
        chk("race_tally3", int'(cnt_out), 1);
        chk("race_total", int'(total), 13);
        cnt_sel = 2'd2;
        tick();
        chk("closed_read2", int'(cnt_out), 5);

        do_reset();
        chk("rst3_ready", int'(ready), 1);
        chk("rst3_total", int'(total), 0);
        chk("rst3_invalid", int'(invalid_cnt), 0);
`ifdef EVM_WINNER_EN
        chk("rst3_valid", int'(result_valid), 0);
        chk("rst3_winner", int'(winner), 0);
        chk("rst3_tie", int'(tie), 0);
`endif
        repeat (2) tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
